// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for the modulo-N up/down counter.
// The master drives the count controls; the slave (the counter) returns q, tc and load_err.
interface mod_n_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, load_err
  );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-N up/down counter with parallel load, terminal count and a sticky
// out-of-range-load flag. Edge priority is rst > load > en > hold.
module mod_n_updown_counter #(
  parameter int N     = 6,
  parameter int WIDTH = 3
) (
  input logic                   clk,
  input logic                   rst,
  mod_n_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             err_r;
  logic             err_next;
  logic             at_max;
  logic             at_min;
  logic             load_ok;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;

  assign at_max  = (q_r == MAX_VAL);
  assign at_min  = (q_r == '0);
  assign load_ok = (bus.load_val <= MAX_VAL);

  // Wrap is an explicit boundary compare, so results match for any N, including N == 2**WIDTH.
  assign q_inc = at_max ? '0 : q_r + WIDTH'(1);
  assign q_dec = at_min ? MAX_VAL : q_r - WIDTH'(1);

  always_comb begin
    q_next   = q_r;
    err_next = err_r;
    if (bus.load) begin
      if (load_ok) q_next = bus.load_val;
      else         err_next = 1'b1;
    end else if (bus.en) begin
      q_next = bus.up_dn ? q_inc : q_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next;
      err_r <= err_next;
    end
  end

  // tc is deliberately not gated by load; cascades treat load as an override at every stage.
  assign bus.tc       = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_min));
  assign bus.q        = q_r;
  assign bus.load_err = err_r;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for the mod-6 up/down counter plus a two-stage cascade and a random sweep.
module tb_mod_n_updown_counter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mod_n_updown_counter_if #(.WIDTH(3)) dut_if ();
  mod_n_updown_counter_if #(.WIDTH(3)) lo_if ();
  mod_n_updown_counter_if #(.WIDTH(3)) hi_if ();

  mod_n_updown_counter #(.N(6), .WIDTH(3)) u_dut (.clk(clk), .rst(rst), .bus(dut_if));
  mod_n_updown_counter #(.N(6), .WIDTH(3)) u_lo  (.clk(clk), .rst(rst), .bus(lo_if));
  mod_n_updown_counter #(.N(6), .WIDTH(3)) u_hi  (.clk(clk), .rst(rst), .bus(hi_if));

  // Cascade wiring: high stage enabled by low stage tc, shared direction, no load.
  assign hi_if.en       = lo_if.tc;
  assign hi_if.up_dn    = lo_if.up_dn;
  assign hi_if.load     = 1'b0;
  assign hi_if.load_val = 3'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dut_if.en       = 1'b0;
    dut_if.up_dn    = 1'b1;
    dut_if.load     = 1'b0;
    dut_if.load_val = 3'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_upwrap();
    logic [2:0] seq [9];
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_cmp++;
    if (dut_if.q !== 3'd0 || dut_if.load_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: q=%0d load_err=%0b required q=0 load_err=0", dut_if.q, dut_if.load_err);
    end
    rst = 1'b0;
    dut_if.en = 1'b1;
    dut_if.up_dn = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (dut_if.q !== seq[i]) begin
        n_err++;
        $display("FAIL up_wrap[%0d]: q=%0d required %0d", i, dut_if.q, seq[i]);
      end
      n_cmp++;
      if (dut_if.tc !== (seq[i] == 3'd5)) begin
        n_err++;
        $display("FAIL up_tc[%0d]: tc=%0b required %0b", i, dut_if.tc, (seq[i] == 3'd5));
      end
      if (i < 8) tick();
    end
  endtask

  task automatic test_down_wrap();
    logic [2:0] seq [8];
    seq = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    do_reset();
    dut_if.en = 1'b1;
    dut_if.up_dn = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dut_if.q !== seq[i]) begin
        n_err++;
        $display("FAIL down_wrap[%0d]: q=%0d required %0d", i, dut_if.q, seq[i]);
      end
      n_cmp++;
      if (dut_if.tc !== (seq[i] == 3'd0)) begin
        n_err++;
        $display("FAIL down_tc[%0d]: tc=%0b required %0b", i, dut_if.tc, (seq[i] == 3'd0));
      end
      if (i < 7) tick();
    end
  endtask

  task automatic test_load_priority();
    logic [2:0] exp_q;
    do_reset();
    dut_if.en = 1'b1;
    dut_if.up_dn = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (dut_if.q !== 3'd2) begin
      n_err++;
      $display("FAIL load_pre: q=%0d required 2", dut_if.q);
    end
    dut_if.load = 1'b1;
    dut_if.load_val = 3'd4;
    tick();
    n_cmp++;
    if (dut_if.q !== 3'd4) begin
      n_err++;
      $display("FAIL load_over_en: q=%0d required 4", dut_if.q);
    end
    dut_if.load_val = 3'd7;
    tick();
    n_cmp++;
    if (dut_if.q !== 3'd4 || dut_if.load_err !== 1'b1) begin
      n_err++;
      $display("FAIL load_illegal: q=%0d load_err=%0b required q=4 load_err=1", dut_if.q, dut_if.load_err);
    end
    dut_if.load = 1'b0;
    exp_q = 3'd4;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_q = (exp_q == 3'd5) ? 3'd0 : exp_q + 3'd1;
      n_cmp++;
      if (dut_if.load_err !== 1'b1 || dut_if.q !== exp_q) begin
        n_err++;
        $display("FAIL err_sticky[%0d]: q=%0d load_err=%0b required q=%0d load_err=1", i, dut_if.q, dut_if.load_err, exp_q);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (dut_if.load_err !== 1'b0 || dut_if.q !== 3'd0) begin
      n_err++;
      $display("FAIL err_clear: q=%0d load_err=%0b required q=0 load_err=0", dut_if.q, dut_if.load_err);
    end
  endtask

  task automatic test_hold_flip();
    logic [2:0] seq [4];
    seq = '{3'd4, 3'd3, 3'd4, 3'd3};
    do_reset();
    dut_if.en = 1'b1;
    dut_if.up_dn = 1'b1;
    tick();
    tick();
    tick();
    dut_if.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dut_if.q !== 3'd3) begin
        n_err++;
        $display("FAIL hold[%0d]: q=%0d required 3", i, dut_if.q);
      end
    end
    dut_if.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dut_if.up_dn = (i % 2 == 0);
      tick();
      n_cmp++;
      if (dut_if.q !== seq[i]) begin
        n_err++;
        $display("FAIL flip[%0d]: q=%0d required %0d", i, dut_if.q, seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dut_if.en = 1'b1;
    dut_if.up_dn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dut_if.load = 1'b1;
    dut_if.load_val = 3'd6;
    tick();
    n_cmp++;
    if (dut_if.q !== 3'd4 || dut_if.load_err !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: q=%0d load_err=%0b required q=4 load_err=1", dut_if.q, dut_if.load_err);
    end
    rst = 1'b1;
    dut_if.load_val = 3'd2;
    tick();
    rst = 1'b0;
    idle_inputs();
    n_cmp++;
    if (dut_if.q !== 3'd0 || dut_if.load_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_over_load: q=%0d load_err=%0b required q=0 load_err=0", dut_if.q, dut_if.load_err);
    end
  endtask

  task automatic test_cascade();
    logic [2:0] m_lo;
    logic [2:0] m_hi;
    rst = 1'b1;
    lo_if.en = 1'b0;
    tick();
    rst = 1'b0;
    lo_if.en = 1'b1;
    lo_if.up_dn = 1'b1;
    m_lo = 3'd0;
    m_hi = 3'd0;
    for (int i = 0; i < 40; i++) begin
      if (m_lo == 3'd5) begin
        m_lo = 3'd0;
        m_hi = (m_hi == 3'd5) ? 3'd0 : m_hi + 3'd1;
      end else begin
        m_lo = m_lo + 3'd1;
      end
      tick();
      n_cmp++;
      if (lo_if.q !== m_lo || hi_if.q !== m_hi) begin
        n_err++;
        $display("FAIL cascade[%0d]: hi=%0d lo=%0d required hi=%0d lo=%0d", i, hi_if.q, lo_if.q, m_hi, m_lo);
      end
    end
    n_cmp++;
    if (hi_if.q !== 3'd0 || lo_if.q !== 3'd4) begin
      n_err++;
      $display("FAIL cascade_end: hi=%0d lo=%0d required hi=0 lo=4", hi_if.q, lo_if.q);
    end
    lo_if.en = 1'b0;
  endtask

  task automatic test_random_range();
    logic [2:0] m_q;
    logic       m_err;
    do_reset();
    m_q = 3'd0;
    m_err = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      dut_if.en       = ($urandom_range(0, 3) != 0);
      dut_if.up_dn    = $urandom_range(0, 1) == 1;
      dut_if.load     = ($urandom_range(0, 7) == 0);
      dut_if.load_val = 3'($urandom_range(0, 7));
      if (dut_if.load) begin
        if (dut_if.load_val <= 3'd5) m_q = dut_if.load_val;
        else m_err = 1'b1;
      end else if (dut_if.en) begin
        if (dut_if.up_dn) m_q = (m_q == 3'd5) ? 3'd0 : m_q + 3'd1;
        else              m_q = (m_q == 3'd0) ? 3'd5 : m_q - 3'd1;
      end
      tick();
      n_cmp++;
      if (dut_if.q >= 3'd6 || dut_if.q !== m_q || dut_if.load_err !== m_err) begin
        n_err++;
        $display("FAIL random[%0d]: q=%0d load_err=%0b required q=%0d load_err=%0b", i, dut_if.q, dut_if.load_err, m_q, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    idle_inputs();
    lo_if.en = 1'b0;
    lo_if.up_dn = 1'b1;
    lo_if.load = 1'b0;
    lo_if.load_val = 3'd0;
    test_reset_upwrap();
    test_down_wrap();
    test_load_priority();
    test_hold_flip();
    test_reset_mid();
    test_cascade();
    test_random_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
